main_host: RTL and testbench
============================

// Module: main_host
// PURPOSE
// Initiator-side sequencer for the main processing core (data_path/control_path pair).
// - Accepts one job (operand + mode) over a valid/ready request port.
// - Drives the core's x/on/start inputs and tracks the core's active handshake to completion.
// - Captures y/s/b/regime into a response register, with timeout protection.
// - Sits between the bench/host logic and main; one job in flight at a time.
// PARAMETERS
// TIMEOUT  255  max cycles spent in WAIT_ACT plus RUN before the job is aborted; must be 1..2^TW-1
// TW       8    width of the timeout counter
// PORTS
// clk          in   1  system clock, rising edge
// rst          in   1  asynchronous, active-low reset
// req_valid    in   1  job request valid
// req_ready    out  1  job accepted when req_valid & req_ready
// req_x        in   8  operand for the core
// req_mode     in   2  value driven on core 'on' for this job
// x            out  8  to core x
// on           out  2  to core on
// start        out  1  to core start, one-cycle pulse
// active       in   1  from core: job running
// y            in   8  from core result
// s            in   3  from core step/state count
// b            in   1  from core flag
// regime       in   2  from core regime
// rsp_valid    out  1  response valid, held until rsp_ready
// rsp_ready    in   1  response consumed when rsp_valid & rsp_ready
// rsp_y        out  8  captured y
// rsp_s        out  3  captured s
// rsp_b        out  1  captured b
// rsp_regime   out  2  regime sampled on the first active-high cycle
// rsp_timeout  out  1  job aborted by timeout
// busy         out  1  state != IDLE
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; all registered outputs are 0; counter=0.
//   req_ready=1 while in IDLE.
// - FSM states:
//   IDLE -> LAUNCH on req_valid & req_ready; req_x and req_mode are latched.
//   LAUNCH: start=1 for exactly 1 cycle; counter cleared; next state WAIT_ACT.
//   WAIT_ACT: wait for active=1.
//     On active=1: latch rsp_regime, go to RUN.
//   RUN: wait for active=0.
//     On active=0: latch y/s/b in that same cycle, go to HOLD with rsp_timeout=0.
//   WAIT_ACT/RUN timeout: counter increments every cycle in these states.
//     If counter==TIMEOUT and the exit condition is not met: latch current y/s/b,
//     set rsp_timeout=1, go to HOLD. The exit condition wins on the same cycle.
//   HOLD: rsp_valid=1; all rsp_* stay stable.
//     On rsp_ready: clear rsp_valid, go to IDLE.
// - x and on:
//   driven from the latched job from LAUNCH through RUN; 0 in IDLE and HOLD.
//   x and on change only in the cycle after acceptance, never mid-job.
// - req_ready=0 in every state except IDLE.
//   A new job can be accepted one cycle after the rsp transfer; no overlap.
// - Latency: acceptance at cycle 0, start at cycle 1.
//   If active falls at cycle m, rsp_valid=1 at cycle m+1.
// - active already 1 in the LAUNCH cycle is ignored; WAIT_ACT samples from cycle 2.
// - req_mode=0 is passed through unchanged; no validation.
// - Reset mid-job: immediate return to IDLE; start/on/x=0; the response is lost.
// TESTING
// 1 Reset: rst=0 mid-RUN -> busy=0, start=0, on=0, x=0, rsp_valid=0, req_ready=1.
// 2 Normal job: req_x=8'h5A, req_mode=2'b01.
//   - start high at cycle 1; active high at 3..7, y=8'h3C, s=3'd5, b=1 at cycle 8.
//   - Required: rsp_valid at cycle 9 with rsp_y=8'h3C, rsp_s=5, rsp_b=1, rsp_timeout=0.
// 3 Backpressure: rsp_ready=0 for 10 cycles.
//   - Required: rsp_* stable, req_ready=0 throughout.
//   - rsp_ready=1 -> IDLE next cycle; a second req is accepted the cycle after.
// 4 Timeout, TIMEOUT=4: active never rises.
//   - Required: rsp_valid with rsp_timeout=1 after 5 cycles in WAIT_ACT; on=0 in HOLD.
// 5 Boundary: active falls exactly on the counter==TIMEOUT cycle -> rsp_timeout=0, data captured.
// 6 Stale active: active=1 during LAUNCH, then 0 for 3 cycles, then 1..0.
//   - Required: capture occurs only on the second fall.

Source files
------------

// File: rtl/main_host.sv
// Job sequencer for the main core: one job in flight, start pulse one cycle after acceptance, response one cycle after active falls.
// Backpressure: req_ready only in IDLE; the response is held stable in HOLD until rsp_ready.
module main_host #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [1:0] req_mode,
  output logic [7:0] x,
  output logic [1:0] on,
  output logic       start,
  input  logic       active,
  input  logic [7:0] y,
  input  logic [2:0] s,
  input  logic       b,
  input  logic [1:0] regime,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_y,
  output logic [2:0] rsp_s,
  output logic       rsp_b,
  output logic [1:0] rsp_regime,
  output logic       rsp_timeout,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACT, RUN, HOLD} state_t;

  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

  state_t          state, state_nxt;
  logic [7:0]      job_x;
  logic [1:0]      job_mode;
  logic [TW-1:0]   cnt;
  logic            cnt_hit;
  logic            capture;
  logic            grab_regime;
  logic            timed_out;
  logic            job_live;

  // Saturating counter plus >= keeps the abort reachable even when active
  // rises on the deadline cycle itself and RUN starts past TIMEOUT.
  assign cnt_hit = (cnt >= TIMEOUT_C);

  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    grab_regime = 1'b0;
    timed_out   = 1'b0;
    case (state)
      IDLE:     if (req_valid) state_nxt = LAUNCH;
      LAUNCH:   state_nxt = WAIT_ACT;
      WAIT_ACT: begin
        if (active) begin
          state_nxt   = RUN;
          grab_regime = 1'b1;
        end else if (cnt_hit) begin
          state_nxt = HOLD;
          capture   = 1'b1;
          timed_out = 1'b1;
        end
      end
      RUN: begin
        if (!active) begin
          state_nxt = HOLD;
          capture   = 1'b1;
        end else if (cnt_hit) begin
          state_nxt = HOLD;
          capture   = 1'b1;
          timed_out = 1'b1;
        end
      end
      HOLD:     if (rsp_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign job_live  = (state == LAUNCH) || (state == WAIT_ACT) || (state == RUN);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign start     = (state == LAUNCH);
  assign rsp_valid = (state == HOLD);
  assign x         = job_live ? job_x : 8'h00;
  assign on        = job_live ? job_mode : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      job_x       <= '0;
      job_mode    <= '0;
      cnt         <= '0;
      rsp_y       <= '0;
      rsp_s       <= '0;
      rsp_b       <= 1'b0;
      rsp_regime  <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        job_x    <= req_x;
        job_mode <= req_mode;
      end
      if (state == LAUNCH) begin
        cnt        <= '0;
        rsp_regime <= '0;
      end else if ((state == WAIT_ACT || state == RUN) && cnt != '1) begin
        cnt <= cnt + TW'(1);
      end
      if (grab_regime) rsp_regime <= regime;
      if (capture) begin
        rsp_y       <= y;
        rsp_s       <= s;
        rsp_b       <= b;
        rsp_timeout <= timed_out;
      end
    end
  end

endmodule

// File: tb/tb_main_host.sv
// Randomized scoreboard bench for main_host: driver pushes expected responses, monitor pops on rsp_valid.
module tb_main_host;
  localparam int TO = 8;
  localparam int D  = 2 + TO;
  localparam int NC = 32;

  logic       clk, rst;
  logic       req_valid, req_ready;
  logic [7:0] req_x;
  logic [1:0] req_mode;
  logic [7:0] x;
  logic [1:0] on;
  logic       start, active;
  logic [7:0] y;
  logic [2:0] s;
  logic       b;
  logic [1:0] regime;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_y;
  logic [2:0] rsp_s;
  logic       rsp_b;
  logic [1:0] rsp_regime;
  logic       rsp_timeout, busy;

  main_host #(.TIMEOUT(TO), .TW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_mode(req_mode),
    .x(x), .on(on), .start(start),
    .active(active), .y(y), .s(s), .b(b), .regime(regime),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_s(rsp_s), .rsp_b(rsp_b), .rsp_regime(rsp_regime),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] y;
    logic [2:0] s;
    logic       b;
    logic [1:0] rg;
    bit         chk_rg;
    bit         to;
    int         vcyc;
  } exp_t;
  exp_t sbq[$];

  // Per-cycle core stimulus, indexed by cycles since acceptance
  bit         act_a[NC];
  logic [7:0] y_a[NC];
  logic [2:0] s_a[NC];
  logic       b_a[NC];
  logic [1:0] rg_a[NC];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic gen(input bit stale, input int k, input int dur);
    for (int c = 0; c < NC; c++) begin
      act_a[c] = 1'b0;
      y_a[c]   = 8'($urandom);
      s_a[c]   = 3'($urandom);
      b_a[c]   = 1'($urandom);
      rg_a[c]  = 2'($urandom);
    end
    act_a[1] = stale;
    for (int c = k; c < k + dur && c < NC; c++) act_a[c] = 1'b1;
  endtask

  task automatic drive_core(input int c);
    active = act_a[c];
    y      = y_a[c];
    s      = s_a[c];
    b      = b_a[c];
    regime = rg_a[c];
  endtask

  // Outcome from the rules: first active at cycle>=2 within the deadline, then its first fall;
  // otherwise the job is aborted at the deadline (or one cycle after a deadline-cycle rise).
  function automatic void model(output int ce, output bit to, output int kc);
    int lim;
    kc = -1;
    ce = D;
    to = 1'b1;
    for (int c = 2; c < NC; c++) if (act_a[c] && kc < 0) kc = c;
    if (kc < 0 || kc > D) return;
    lim = (kc + 1 > D) ? kc + 1 : D;
    ce = lim;
    for (int c = kc + 1; c <= lim; c++) begin
      if (!act_a[c]) begin
        ce = c;
        to = 1'b0;
        break;
      end
    end
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("idle_wait_expired", 0, 1);
  endtask

  task automatic do_job(input logic [7:0] jx, input logic [1:0] jm, input int stall);
    int ce, kc, acc;
    bit to;
    exp_t e;
    model(ce, to, kc);
    wait_idle();
    req_valid = 1'b1;
    req_x     = jx;
    req_mode  = jm;
    drive_core(0);
    acc       = cyc;
    e.y       = y_a[ce];
    e.s       = s_a[ce];
    e.b       = b_a[ce];
    e.to      = to;
    e.chk_rg  = (kc >= 2 && kc <= D);
    e.rg      = e.chk_rg ? rg_a[kc] : 2'b00;
    e.vcyc    = acc + ce + 1;
    sbq.push_back(e);
    for (int c = 1; c <= ce; c++) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom);
      req_x     = 8'($urandom);
      req_mode  = 2'($urandom);
      drive_core(c);
      chk("start", start, (c == 1));
      chk("x_job", x, jx);
      chk("on_job", on, jm);
      chk("busy_job", busy, 1);
    end
    @(posedge clk); #1;
    active = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("req_ready_after_rsp", req_ready, 1);
  endtask

  // Monitor: compares every HOLD cycle against the expected response, pops on transfer
  initial begin : monitor
    bit have = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        have = 1'b0;
        continue;
      end
      if (rsp_valid) begin
        if (!have) begin
          if (sbq.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
          end else begin
            e = sbq.pop_front();
            have = 1'b1;
            chk("rsp_cycle", cyc, e.vcyc);
          end
        end
        if (have) begin
          chk("rsp_y", rsp_y, e.y);
          chk("rsp_s", rsp_s, e.s);
          chk("rsp_b", rsp_b, e.b);
          chk("rsp_timeout", rsp_timeout, e.to);
          if (e.chk_rg) chk("rsp_regime", rsp_regime, e.rg);
          chk("req_ready_hold", req_ready, 0);
          chk("on_hold", on, 0);
          chk("x_hold", x, 0);
          if (rsp_ready) have = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    req_valid = 1'b0; req_x = '0; req_mode = '0;
    active = 1'b0; y = '0; s = '0; b = 1'b0; regime = '0;
    rsp_ready = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_start", start, 0);
    chk("rst_x", x, 0);
    chk("rst_on", on, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Normal job: active 3..7, result presented on cycle 8
    gen(0, 3, 5);
    y_a[8] = 8'h3C; s_a[8] = 3'd5; b_a[8] = 1'b1;
    do_job(8'h5A, 2'b01, 0);
    // Backpressure, then an immediate second job
    gen(0, 4, 3);
    do_job(8'hA5, 2'b10, 10);
    gen(0, 2, 2);
    do_job(8'h11, 2'b00, 0);
    // Timeout with active never rising
    gen(0, NC, 0);
    do_job(8'h77, 2'b11, 2);
    // Fall exactly on the deadline cycle, then one cycle too late
    gen(0, 3, D - 3);
    do_job(8'h42, 2'b01, 1);
    gen(0, 3, D - 2);
    do_job(8'h43, 2'b01, 0);
    // Rise on the deadline cycle
    gen(0, D, 4);
    do_job(8'h44, 2'b10, 0);
    // Stale active during LAUNCH, real run later
    gen(1, 5, 3);
    do_job(8'h99, 2'b11, 3);

    // Reset in the middle of RUN drops the job
    gen(0, 3, 8);
    wait_idle();
    req_valid = 1'b1; req_x = 8'hE1; req_mode = 2'b10;
    drive_core(0);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      drive_core(c);
    end
    chk("busy_before_rst", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_start", start, 0);
    chk("mid_rst_on", on, 0);
    chk("mid_rst_x", x, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    active = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int j = 0; j < 40; j++) begin
      gen(1'($urandom), $urandom_range(2, D + 2), $urandom_range(0, D));
      do_job(8'($urandom), 2'($urandom), $urandom_range(0, 4));
    end

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
